i2c_passthru_mst_arb: RTL and testbench

I2C_PASSTHRU_MST_ARB -- requirements
Module: i2c_passthru_mst_arb

---
 rtl/i2c_passthru_pkg.sv | 14 +
 rtl/i2c_passthru_cond_det.sv | 26 ++
 rtl/i2c_passthru_mst_arb.sv | 147 ++++++++++++++
 tb/tb_i2c_passthru_mst_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_passthru_pkg.sv
// Shared state encoding and counter widths for the I2C pass-through master arbiter.
package i2c_passthru_pkg;

    localparam int LOW_CNT_W  = 16;
    localparam int FREE_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_A    = 2'd1,
        ST_OWN_B    = 2'd2,
        ST_BUS_FREE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/i2c_passthru_cond_det.sv
// Per-channel I2C start/stop condition detector; SDA is delayed one cycle and
// compared against the live level while SCL is high.
module i2c_passthru_cond_det (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_start,
    output logic o_stop
);

    logic prev_sda;

    // Idle-high reset value so a bus held high after reset shows no edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prev_sda <= 1'b1;
        end else begin
            prev_sda <= i_sda;
        end
    end

    assign o_start = i_scl & prev_sda & ~i_sda;
    assign o_stop  = i_scl & ~prev_sda & i_sda;

endmodule

// File: rtl/i2c_passthru_mst_arb.sv
// Arbitrates ownership between two upstream I2C master channels: first start
// wins, stop or stuck-SCL timeout releases, then a bus-free guard time follows.
module i2c_passthru_mst_arb #(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned FREE_CYC    = 64
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_cha_scl,
    input  logic       i_cha_sda,
    input  logic       i_chb_scl,
    input  logic       i_chb_sda,
    output logic       o_grant,
    output logic       o_grant_chb,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_timeout,
    output logic       o_collision,
    output logic [1:0] o_dbg_state
);

    import i2c_passthru_pkg::*;

    localparam logic [LOW_CNT_W-1:0]  LOW_LAST  = LOW_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [FREE_CNT_W-1:0] FREE_LAST = FREE_CNT_W'(FREE_CYC - 1);

    arb_state_t              state;
    logic [LOW_CNT_W-1:0]    low_cnt;
    logic [FREE_CNT_W-1:0]   free_cnt;
    logic                    start_a, stop_a, start_b, stop_b;
    logic                    own_scl, own_start, own_stop, oth_start;
    logic                    all_high;
    logic [LOW_CNT_W-1:0]    low_inc;
    logic [FREE_CNT_W-1:0]   free_inc;

    i2c_passthru_cond_det u_det_a (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_scl   (i_cha_scl),
        .i_sda   (i_cha_sda),
        .o_start (start_a),
        .o_stop  (stop_a)
    );

    i2c_passthru_cond_det u_det_b (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_scl   (i_chb_scl),
        .i_sda   (i_chb_sda),
        .o_start (start_b),
        .o_stop  (stop_b)
    );

    always_comb begin
        own_scl   = i_cha_scl;
        own_start = start_a;
        own_stop  = stop_a;
        oth_start = start_b;
        if (state == ST_OWN_B) begin
            own_scl   = i_chb_scl;
            own_start = start_b;
            own_stop  = stop_b;
            oth_start = start_a;
        end
    end

    assign all_high = i_cha_scl & i_cha_sda & i_chb_scl & i_chb_sda;
    // Saturating increments: counters stick at all-ones rather than wrap.
    assign low_inc  = (low_cnt == '1)  ? low_cnt  : low_cnt + LOW_CNT_W'(1);
    assign free_inc = (free_cnt == '1) ? free_cnt : free_cnt + FREE_CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_BUS_FREE;
            low_cnt     <= '0;
            free_cnt    <= '0;
            o_grant     <= 1'b0;
            o_grant_chb <= 1'b0;
            o_start     <= 1'b0;
            o_stop      <= 1'b0;
            o_timeout   <= 1'b0;
            o_collision <= 1'b0;
        end else begin
            o_start     <= 1'b0;
            o_stop      <= 1'b0;
            o_timeout   <= 1'b0;
            o_collision <= 1'b0;
            case (state)
                ST_IDLE: begin
                    low_cnt  <= '0;
                    free_cnt <= '0;
                    if (start_a) begin
                        state       <= ST_OWN_A;
                        o_grant     <= 1'b1;
                        o_grant_chb <= 1'b0;
                        o_start     <= 1'b1;
                        o_collision <= start_b;
                    end else if (start_b) begin
                        state       <= ST_OWN_B;
                        o_grant     <= 1'b1;
                        o_grant_chb <= 1'b1;
                        o_start     <= 1'b1;
                    end
                end
                ST_OWN_A, ST_OWN_B: begin
                    o_start     <= own_start;
                    o_collision <= oth_start;
                    free_cnt    <= '0;
                    // Stop outranks timeout when both land in one cycle.
                    if (own_stop) begin
                        state   <= ST_BUS_FREE;
                        o_grant <= 1'b0;
                        o_stop  <= 1'b1;
                        low_cnt <= '0;
                    end else if (!own_scl && low_cnt == LOW_LAST) begin
                        state     <= ST_BUS_FREE;
                        o_grant   <= 1'b0;
                        o_timeout <= 1'b1;
                        low_cnt   <= '0;
                    end else begin
                        low_cnt <= own_scl ? '0 : low_inc;
                    end
                end
                ST_BUS_FREE: begin
                    low_cnt <= '0;
                    if (!all_high) begin
                        free_cnt <= '0;
                    end else if (free_cnt == FREE_LAST) begin
                        state    <= ST_IDLE;
                        free_cnt <= '0;
                    end else begin
                        free_cnt <= free_inc;
                    end
                end
                default: begin
                    state    <= ST_BUS_FREE;
                    low_cnt  <= '0;
                    free_cnt <= '0;
                    o_grant  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_i2c_passthru_mst_arb.sv
// Directed bench for the I2C pass-through master arbiter.
module tb_i2c_passthru_mst_arb;

    import i2c_passthru_pkg::*;

    localparam int TO_CYC = 100;
    localparam int FR_CYC = 64;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       a_scl = 1'b1, a_sda = 1'b1, b_scl = 1'b1, b_sda = 1'b1;
    logic       grant, grant_chb, start_p, stop_p, timeout_p, collision_p;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2c_passthru_mst_arb #(
        .TIMEOUT_CYC (TO_CYC),
        .FREE_CYC    (FR_CYC)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_cha_scl   (a_scl),
        .i_cha_sda   (a_sda),
        .i_chb_scl   (b_scl),
        .i_chb_sda   (b_sda),
        .o_grant     (grant),
        .o_grant_chb (grant_chb),
        .o_start     (start_p),
        .o_stop      (stop_p),
        .o_timeout   (timeout_p),
        .o_collision (collision_p),
        .o_dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input bit chb, input logic scl, input logic sda);
        if (chb) begin
            b_scl = scl;
            b_sda = sda;
        end else begin
            a_scl = scl;
            a_sda = sda;
        end
    endtask

    // Leaves the channel one drive away from a stop: caller raises SDA and ticks.
    task automatic pre_stop(input bit chb);
        set_ch(chb, 1'b0, 1'b0);
        tick();
        set_ch(chb, 1'b1, 1'b0);
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (dbg_state == ST_IDLE) seen = 1'b1;
        end
        check(tag, n, FR_CYC);
    endtask

    task automatic check_outs(input string tag, input logic g, input logic chb,
                              input logic st, input logic sp, input logic to, input logic co);
        check({tag, "_grant"}, grant, g);
        if (g) check({tag, "_chb"}, grant_chb, chb);
        check({tag, "_start"}, start_p, st);
        check({tag, "_stop"}, stop_p, sp);
        check({tag, "_timeout"}, timeout_p, to);
        check({tag, "_coll"}, collision_p, co);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_state", dbg_state, ST_BUS_FREE);
        rstn = 1'b1;
        wait_idle("rst_to_idle");

        // A start, latency one cycle
        a_sda = 1'b0;
        tick();
        check_outs("a_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("a_start_state", dbg_state, ST_OWN_A);
        pre_stop(1'b0);
        check("a_start_pulse_once", start_p, 1'b0);
        a_sda = 1'b1;
        tick();
        check_outs("a_stop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("a_stop_state", dbg_state, ST_BUS_FREE);

        // B glitch at free cycle 30 restarts the free count; start here is ignored
        repeat (30) tick();
        check("glitch_pre_state", dbg_state, ST_BUS_FREE);
        check("stop_pulse_once", stop_p, 1'b0);
        b_sda = 1'b0;
        tick();
        check("glitch_coll", collision_p, 1'b0);
        check("glitch_start", start_p, 1'b0);
        check("glitch_grant", grant, 1'b0);
        b_sda = 1'b1;
        wait_idle("glitch_to_idle");

        // Simultaneous starts: A wins with collision
        a_sda = 1'b0;
        b_sda = 1'b0;
        tick();
        check_outs("sim", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("sim_next", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b_sda = 1'b1;
        tick();
        check_outs("sim_b_stop_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pre_stop(1'b0);
        a_sda = 1'b1;
        tick();
        check("sim_a_stop", stop_p, 1'b1);
        wait_idle("sim_to_idle");

        // Owner B: repeated start on B, then start on A
        b_sda = 1'b0;
        tick();
        check_outs("b_start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("b_start_state", dbg_state, ST_OWN_B);
        set_ch(1'b1, 1'b0, 1'b0); tick();
        set_ch(1'b1, 1'b0, 1'b1); tick();
        set_ch(1'b1, 1'b1, 1'b1); tick();
        check("b_sr_setup_start", start_p, 1'b0);
        set_ch(1'b1, 1'b1, 1'b0);
        tick();
        check_outs("b_rstart", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        a_sda = 1'b0;
        tick();
        check_outs("b_coll", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        a_sda = 1'b1;
        tick();
        check_outs("b_a_stop_ignored", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pre_stop(1'b1);
        b_sda = 1'b1;
        tick();
        check_outs("b_stop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b_chb_hold", grant_chb, 1'b1);
        wait_idle("b_to_idle");

        // Timeout: 99 low cycles then release, then exactly 100 low cycles
        a_sda = 1'b0;
        tick();
        check("to_grant", grant, 1'b1);
        a_scl = 1'b0;
        repeat (TO_CYC - 1) tick();
        check_outs("to_99", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        a_scl = 1'b1;
        tick();
        check_outs("to_99_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        a_scl = 1'b0;
        repeat (TO_CYC - 1) tick();
        check_outs("to_99b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("to_100", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("to_state", dbg_state, ST_BUS_FREE);
        check("to_chb_hold", grant_chb, 1'b0);
        tick();
        check("to_pulse_once", timeout_p, 1'b0);
        a_scl = 1'b1;
        a_sda = 1'b1;
        wait_idle("to_to_idle");

        // Asynchronous reset while owning
        a_sda = 1'b0;
        tick();
        check("ar_grant", grant, 1'b1);
        a_scl = 1'b0;
        repeat (5) tick();
        #2;
        rstn = 1'b0;
        #1;
        check("ar_async_grant", grant, 1'b0);
        check("ar_async_state", dbg_state, ST_BUS_FREE);
        tick();
        check_outs("ar_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        a_scl = 1'b1;
        a_sda = 1'b1;
        rstn  = 1'b1;
        wait_idle("ar_to_idle");
        a_sda = 1'b0;
        tick();
        check_outs("ar_regrant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
